// File: rtl/fpu_issue_ctrl_if.sv
// rtl/fpu_issue_ctrl_if.sv - operand/select bus between the issue sequencer and the fp16 vector FPU
// master = sequencer (drives operands and selects), slave = FPU (drives results)
interface fpu_issue_ctrl_if #(
   parameter int LANES = 16
);
   logic [16*LANES-1:0] Va;
   logic [16*LANES-1:0] Vb;
   logic [15:0]         Sa;
   logic [15:0]         Sb;
   logic                VADD;
   logic                VDOT;
   logic                SMUL;
   logic [16*LANES-1:0] fpu_vout;
   logic [15:0]         fpu_sout;
   logic                fpu_v;

   modport master (
      output Va, Vb, Sa, Sb, VADD, VDOT, SMUL,
      input  fpu_vout, fpu_sout, fpu_v
   );

   modport slave (
      input  Va, Vb, Sa, Sb, VADD, VDOT, SMUL,
      output fpu_vout, fpu_sout, fpu_v
   );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - start/done sequencer that holds operands on the fp16 FPU, settles, then captures results
// Optional per-lane result write mask: define LANE_MASK_EN.
module fpu_issue_ctrl #(
   parameter int SETTLE_CYCLES = 2,
   parameter int LANES         = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [1:0]          opcode,
   input  logic [16*LANES-1:0] va_in,
   input  logic [16*LANES-1:0] vb_in,
   input  logic [15:0]         sa_in,
   input  logic [15:0]         sb_in,
`ifdef LANE_MASK_EN
   input  logic [LANES-1:0]    lane_mask,
`endif
   input  logic                clr_ovf,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [16*LANES-1:0] vres,
   output logic [15:0]         sres,
   output logic                ovf,
   fpu_issue_ctrl_if.master    fpu
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_CAPTURE,
      S_DONE
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

   state_t     state;
   logic [3:0] cnt;
   logic [1:0] op_q;
`ifdef LANE_MASK_EN
   logic [LANES-1:0] mask_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         op_q     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         vres     <= '0;
         sres     <= '0;
         ovf      <= 1'b0;
         fpu.Va   <= '0;
         fpu.Vb   <= '0;
         fpu.Sa   <= '0;
         fpu.Sb   <= '0;
         fpu.VADD <= 1'b0;
         fpu.VDOT <= 1'b0;
         fpu.SMUL <= 1'b0;
`ifdef LANE_MASK_EN
         mask_q   <= '0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         // A capture setting ovf later in this block overrides a coincident clear.
         if (clr_ovf) ovf <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start) begin
                  fpu.Va   <= va_in;
                  fpu.Vb   <= vb_in;
                  fpu.Sa   <= sa_in;
                  fpu.Sb   <= sb_in;
                  op_q     <= opcode;
                  fpu.VADD <= (opcode == 2'b00);
                  fpu.VDOT <= (opcode == 2'b01);
                  fpu.SMUL <= (opcode == 2'b10);
`ifdef LANE_MASK_EN
                  mask_q   <= lane_mask;
`endif
                  busy     <= 1'b1;
                  state    <= S_ISSUE;
               end
            end

            // ISSUE counts as the first settle cycle; WAIT covers the rest.
            S_ISSUE: begin
               if (op_q == 2'b11) begin
                  done  <= 1'b1;
                  err   <= 1'b1;
                  state <= S_DONE;
               end else if (CNT_INIT == 4'd0) begin
                  state <= S_CAPTURE;
               end else begin
                  cnt   <= CNT_INIT;
                  state <= S_WAIT;
               end
            end

            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt <= 4'd1) state <= S_CAPTURE;
            end

            S_CAPTURE: begin
`ifdef LANE_MASK_EN
               for (int i = 0; i < LANES; i++) begin
                  if (mask_q[i]) vres[16*i +: 16] <= fpu.fpu_vout[16*i +: 16];
               end
`else
               vres <= fpu.fpu_vout;
`endif
               sres <= fpu.fpu_sout;
               if (fpu.fpu_v) ovf <= 1'b1;
               fpu.VADD <= 1'b0;
               fpu.VDOT <= 1'b0;
               fpu.SMUL <= 1'b0;
               done     <= 1'b1;
               state    <= S_DONE;
            end

            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
